// File: rtl/vita49_pack_if.sv
// AXI-Stream bundle shared by the packetizer's sample input and packet output.
interface vita49_pack_if;
    logic [31:0] TDATA;
    logic        TVALID;
    logic        TLAST;
    logic        TREADY;

    modport master (
        output TDATA,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/vita49_pack.sv
// VITA-49 signal-data packetizer: wraps a raw 32-bit sample stream into
// header / stream ID / optional TSI+TSF / payload packets with TLAST framing.
module vita49_pack (
    input  logic          AXIS_ACLK,
    input  logic          AXIS_ARESETN,
    vita49_pack_if.slave  s_axis,
    vita49_pack_if.master m_axis,
    input  logic [31:0]   ctrl,
    output logic [31:0]   status,
    input  logic [31:0]   streamID,
    input  logic [15:0]   payload_len,
    input  logic [31:0]   words_to_pack,
    input  logic [31:0]   timestamp_sec,
    input  logic [63:0]   timestamp_fsec
);

    typedef enum logic [3:0] {
        P_INIT    = 4'd0,
        P_WAIT    = 4'd1,
        P_HDR     = 4'd2,
        P_STRM_ID = 4'd3,
        P_TSI     = 4'd4,
        P_TSF_0   = 4'd5,
        P_TSF_1   = 4'd6,
        P_PAYLOAD = 4'd7,
        P_DONE    = 4'd8,
        P_ERROR   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [3:0]  pkt_cnt_q, pkt_cnt_d;
    logic        done_q, done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        ts_en_q, ts_en_d;
    logic [31:0] stream_id_q, stream_id_d;
    logic [31:0] ts_sec_q, ts_sec_d;
    logic [63:0] ts_fsec_q, ts_fsec_d;
    logic [15:0] this_len_q, this_len_d;
    logic [15:0] pkt_size_q, pkt_size_d;

    logic        cmd_start;
    logic        cmd_reset;
    logic        cmd_pass;
    logic        cmd_ts_en;
    logic        unused_ctrl;

    logic [31:0] remain;
    logic [15:0] len_sel;
    logic [31:0] hdr_word;
    logic        pay_last;
    logic        m_xfr;

    assign cmd_start   = ctrl[0];
    assign cmd_reset   = ctrl[1];
    assign cmd_pass    = ctrl[2];
    assign cmd_ts_en   = ctrl[3];
    assign unused_ctrl = ^ctrl[31:4];

    // Remaining words decide whether this packet is full-size or the short tail.
    assign remain  = words_to_pack - word_cnt_q;
    assign len_sel = (remain < {16'd0, payload_len}) ? remain[15:0] : payload_len;

    assign hdr_word = {4'b0001, 1'b0, 1'b0, 2'b00,
                       ts_en_q ? 2'b01 : 2'b00,
                       ts_en_q ? 2'b10 : 2'b00,
                       pkt_cnt_q, pkt_size_q};

    assign pay_last = ((pay_cnt_q + 16'd1) == this_len_q);
    assign m_xfr    = m_axis.TVALID & m_axis.TREADY;

    assign status = {cmd_start, cmd_reset, cmd_pass, cmd_ts_en,
                     state_q, pkt_cnt_q, 18'd0, cfg_err_q, done_q};

    // Output mux: header words come from latched registers, payload is a
    // combinational pass-through so the data path adds no latency.
    always_comb begin
        m_axis.TDATA  = 32'd0;
        m_axis.TVALID = 1'b0;
        m_axis.TLAST  = 1'b0;
        s_axis.TREADY = 1'b0;
        if (cmd_pass) begin
            m_axis.TDATA  = s_axis.TDATA;
            m_axis.TVALID = s_axis.TVALID;
            m_axis.TLAST  = s_axis.TLAST;
            s_axis.TREADY = m_axis.TREADY;
        end else begin
            case (state_q)
                P_HDR: begin
                    m_axis.TDATA  = hdr_word;
                    m_axis.TVALID = 1'b1;
                end
                P_STRM_ID: begin
                    m_axis.TDATA  = stream_id_q;
                    m_axis.TVALID = 1'b1;
                end
                P_TSI: begin
                    m_axis.TDATA  = ts_sec_q;
                    m_axis.TVALID = 1'b1;
                end
                P_TSF_0: begin
                    m_axis.TDATA  = ts_fsec_q[63:32];
                    m_axis.TVALID = 1'b1;
                end
                P_TSF_1: begin
                    m_axis.TDATA  = ts_fsec_q[31:0];
                    m_axis.TVALID = 1'b1;
                end
                P_PAYLOAD: begin
                    m_axis.TDATA  = s_axis.TDATA;
                    m_axis.TVALID = s_axis.TVALID;
                    m_axis.TLAST  = pay_last;
                    s_axis.TREADY = m_axis.TREADY;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        done_d      = done_q;
        cfg_err_d   = cfg_err_q;
        ts_en_d     = ts_en_q;
        stream_id_d = stream_id_q;
        ts_sec_d    = ts_sec_q;
        ts_fsec_d   = ts_fsec_q;
        this_len_d  = this_len_q;
        pkt_size_d  = pkt_size_q;

        // reset_cmd wins even in passthrough; otherwise passthrough freezes everything.
        if (cmd_reset) begin
            state_d = P_INIT;
        end else if (!cmd_pass) begin
            case (state_q)
                P_INIT: begin
                    word_cnt_d = 32'd0;
                    pay_cnt_d  = 16'd0;
                    pkt_cnt_d  = 4'd0;
                    done_d     = 1'b0;
                    cfg_err_d  = 1'b0;
                    if (cmd_start) begin
                        if (payload_len == 16'd0 || payload_len > 16'd65530) begin
                            cfg_err_d = 1'b1;
                            state_d   = P_ERROR;
                        end else if (words_to_pack == 32'd0) begin
                            state_d = P_DONE;
                        end else begin
                            state_d = P_WAIT;
                        end
                    end
                end
                P_WAIT: begin
                    if (s_axis.TVALID) begin
                        ts_en_d     = cmd_ts_en;
                        stream_id_d = streamID;
                        ts_sec_d    = timestamp_sec;
                        ts_fsec_d   = timestamp_fsec;
                        this_len_d  = len_sel;
                        pkt_size_d  = len_sel + (cmd_ts_en ? 16'd5 : 16'd2);
                        state_d     = P_HDR;
                    end
                end
                P_HDR: begin
                    if (m_xfr) state_d = P_STRM_ID;
                end
                P_STRM_ID: begin
                    if (m_xfr) state_d = ts_en_q ? P_TSI : P_PAYLOAD;
                end
                P_TSI: begin
                    if (m_xfr) state_d = P_TSF_0;
                end
                P_TSF_0: begin
                    if (m_xfr) state_d = P_TSF_1;
                end
                P_TSF_1: begin
                    if (m_xfr) state_d = P_PAYLOAD;
                end
                P_PAYLOAD: begin
                    if (m_xfr) begin
                        word_cnt_d = word_cnt_q + 32'd1;
                        pay_cnt_d  = pay_cnt_q + 16'd1;
                        if (pay_last) begin
                            pay_cnt_d = 16'd0;
                            pkt_cnt_d = pkt_cnt_q + 4'd1;
                            state_d   = ((word_cnt_q + 32'd1) >= words_to_pack) ? P_DONE : P_WAIT;
                        end
                    end
                end
                P_DONE: ;
                P_ERROR: ;
                default: state_d = P_INIT;
            endcase
            if (state_d == P_DONE) done_d = 1'b1;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= P_INIT;
            word_cnt_q  <= 32'd0;
            pay_cnt_q   <= 16'd0;
            pkt_cnt_q   <= 4'd0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            ts_en_q     <= 1'b0;
            stream_id_q <= 32'd0;
            ts_sec_q    <= 32'd0;
            ts_fsec_q   <= 64'd0;
            this_len_q  <= 16'd0;
            pkt_size_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            ts_en_q     <= ts_en_d;
            stream_id_q <= stream_id_d;
            ts_sec_q    <= ts_sec_d;
            ts_fsec_q   <= ts_fsec_d;
            this_len_q  <= this_len_d;
            pkt_size_q  <= pkt_size_d;
        end
    end

endmodule

// File: tb/tb_vita49_pack.sv
// Self-checking bench for vita49_pack: drives a sample stream, captures packet
// words and compares them against a packet-level model of the format.
module tb_vita49_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] ctrl, status, stream_id, wtp, sec;
    logic [15:0] plen;
    logic [63:0] fsec;
    bit          ts_sel;

    vita49_pack_if s_if ();
    vita49_pack_if m_if ();

    vita49_pack dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESETN   (rst_n),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .ctrl           (ctrl),
        .status         (status),
        .streamID       (stream_id),
        .payload_len    (plen),
        .words_to_pack  (wtp),
        .timestamp_sec  (sec),
        .timestamp_fsec (fsec)
    );

    int vectors = 0;
    int miscompares = 0;
    int stall_errs;
    bit timed_out;

    logic [31:0] src_q[$];
    logic [31:0] got_d[$];
    bit          got_l[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];

    // Packet-level reference: walk the sample list, cut it into packets and
    // emit the word list each packet must appear as.
    task automatic build_expected();
        int wc = 0;
        int pc = 0;
        int len;
        exp_d.delete();
        exp_l.delete();
        while (wc < int'(wtp)) begin
            len = (int'(wtp) - wc < int'(plen)) ? int'(wtp) - wc : int'(plen);
            exp_d.push_back({4'h1, 4'h0, ts_sel ? 4'h6 : 4'h0, 4'(pc), 16'(len + (ts_sel ? 5 : 2))});
            exp_l.push_back(1'b0);
            exp_d.push_back(stream_id); exp_l.push_back(1'b0);
            if (ts_sel) begin
                exp_d.push_back(sec);          exp_l.push_back(1'b0);
                exp_d.push_back(fsec[63:32]);  exp_l.push_back(1'b0);
                exp_d.push_back(fsec[31:0]);   exp_l.push_back(1'b0);
            end
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(src_q[wc + i]);
                exp_l.push_back(i == len - 1);
            end
            wc += len;
            pc = (pc + 1) % 16;
        end
    endtask

    task automatic reset_cmd_pulse();
        @(negedge clk);
        ctrl = {28'd0, ts_sel, 3'b010};
        s_if.TVALID = 1'b0;
        @(negedge clk);
        ctrl = {28'd0, ts_sel, 3'b000};
    endtask

    task automatic kick();
        @(negedge clk);
        ctrl = {28'd0, ts_sel, 3'b001};
        @(negedge clk);
        ctrl = {28'd0, ts_sel, 3'b000};
    endtask

    task automatic fill_src(input int n, input bit rnd);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(rnd ? $urandom : 32'(i));
    endtask

    // Source/sink driver: feeds src_q with optional random TVALID gaps and
    // random TREADY stalls, captures every accepted output word.
    task automatic run_stream(input bit throttle, input int stop_after, input int budget);
        int src_idx = 0;
        bit s_acc = 1'b0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_data = 32'd0;
        int cyc = 0;
        got_d.delete();
        got_l.delete();
        stall_errs = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (stop_after > 0 && got_d.size() >= stop_after) break;
            if (status[0] && src_idx >= src_q.size()) break;
            if (cyc >= budget) begin timed_out = 1'b1; break; end
            cyc++;
            if (!(s_if.TVALID && !s_acc)) begin
                if (src_idx < src_q.size()) begin
                    s_if.TVALID = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
                    s_if.TDATA  = src_q[src_idx];
                end else begin
                    s_if.TVALID = 1'b0;
                end
            end
            s_if.TLAST  = 1'b0;
            m_if.TREADY = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (prev_stall && m_if.TDATA !== prev_data) stall_errs++;
            if (m_if.TVALID && m_if.TREADY) begin
                got_d.push_back(m_if.TDATA);
                got_l.push_back(m_if.TLAST);
            end
            prev_stall = m_if.TVALID && !m_if.TREADY;
            prev_data  = m_if.TDATA;
            s_acc      = s_if.TVALID && s_if.TREADY;
            if (s_acc) src_idx++;
        end
        s_if.TVALID = 1'b0;
    endtask

    task automatic setup_ts_scenario();
        ts_sel    = 1'b1;
        stream_id = 32'hCAFE0001;
        plen      = 16'd4;
        wtp       = 32'd8;
        sec       = 32'h10;
        fsec      = 64'h1_00000002;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (m_if.TVALID !== 1'b0 || m_if.TLAST !== 1'b0 || m_if.TDATA !== 32'd0 || s_if.TREADY !== 1'b0) begin
            $display("FAIL reset_outputs: got tvalid=%b tlast=%b tdata=%h tready=%b, required 0/0/0/0",
                     m_if.TVALID, m_if.TLAST, m_if.TDATA, s_if.TREADY);
            miscompares++;
        end
        vectors++;
        if (status !== 32'd0) begin
            $display("FAIL reset_status: got %h required 00000000", status);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: outputs and status sampled in reset");
    endtask

    task automatic test_ts_packets();
        setup_ts_scenario();
        fill_src(8, 1'b0);
        build_expected();
        reset_cmd_pulse();
        kick();
        run_stream(1'b0, 0, 500);
        vectors++;
        if (timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL ts_count: got %0d words (timeout=%0d) required %0d", got_d.size(), timed_out, exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL ts_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        vectors++;
        if (got_d.size() >= 18 && (got_d[0] !== 32'h10600009 || got_d[9] !== 32'h10610009 || got_l[8] !== 1'b1 || got_l[17] !== 1'b1)) begin
            $display("FAIL ts_headers: got %h/%h last8=%0d required 10600009/10610009 last8=1", got_d[0], got_d[9], got_l[8]);
            miscompares++;
        end
        vectors++;
        if (status[0] !== 1'b1) begin
            $display("FAIL ts_done: got %b required 1", status[0]);
            miscompares++;
        end
        $display("test_ts_packets: %0d words captured", got_d.size());
    endtask

    task automatic test_no_ts();
        ts_sel    = 1'b0;
        stream_id = $urandom;
        plen      = 16'd3;
        wtp       = 32'd7;
        fill_src(7, 1'b1);
        build_expected();
        reset_cmd_pulse();
        kick();
        run_stream(1'b0, 0, 500);
        vectors++;
        if (timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL nots_count: got %0d words (timeout=%0d) required %0d", got_d.size(), timed_out, exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL nots_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        vectors++;
        if (got_d.size() == 13 && (got_d[0] !== 32'h10000005 || got_d[5] !== 32'h10010005 || got_d[10] !== 32'h10020003)) begin
            $display("FAIL nots_headers: got %h/%h/%h required 10000005/10010005/10020003", got_d[0], got_d[5], got_d[10]);
            miscompares++;
        end
        vectors++;
        if (status[0] !== 1'b1) begin
            $display("FAIL nots_done: got %b required 1", status[0]);
            miscompares++;
        end
        $display("test_no_ts: %0d words captured", got_d.size());
    endtask

    task automatic test_throttle();
        setup_ts_scenario();
        fill_src(8, 1'b0);
        build_expected();
        reset_cmd_pulse();
        kick();
        run_stream(1'b1, 0, 2000);
        vectors++;
        if (timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL thr_count: got %0d words (timeout=%0d) required %0d", got_d.size(), timed_out, exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL thr_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        vectors++;
        if (stall_errs !== 0) begin
            $display("FAIL thr_stable: got %0d tdata changes under stall, required 0", stall_errs);
            miscompares++;
        end
        $display("test_throttle: %0d words captured", got_d.size());
    endtask

    task automatic test_pkt_cnt_wrap();
        ts_sel    = 1'b0;
        stream_id = 32'h5EED0042;
        plen      = 16'd1;
        wtp       = 32'd17;
        fill_src(17, 1'b1);
        build_expected();
        reset_cmd_pulse();
        kick();
        run_stream(1'b0, 0, 1000);
        vectors++;
        if (timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL wrap_count: got %0d words (timeout=%0d) required %0d", got_d.size(), timed_out, exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL wrap_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        $display("test_pkt_cnt_wrap: %0d words captured", got_d.size());
    endtask

    task automatic test_reset_cmd();
        setup_ts_scenario();
        fill_src(8, 1'b1);
        reset_cmd_pulse();
        kick();
        run_stream(1'b0, 7, 500);
        @(negedge clk);
        ctrl = {28'd0, ts_sel, 3'b010};
        s_if.TVALID = 1'b0;
        @(negedge clk);
        ctrl = {28'd0, ts_sel, 3'b000};
        #1;
        vectors++;
        if (m_if.TVALID !== 1'b0 || s_if.TREADY !== 1'b0 || status[27:24] !== 4'd0) begin
            $display("FAIL rcmd_idle: got tvalid=%b tready=%b state=%0d required 0/0/0", m_if.TVALID, s_if.TREADY, status[27:24]);
            miscompares++;
        end
        fill_src(8, 1'b1);
        build_expected();
        kick();
        run_stream(1'b0, 0, 500);
        vectors++;
        if (timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL rcmd_count: got %0d words (timeout=%0d) required %0d", got_d.size(), timed_out, exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL rcmd_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        $display("test_reset_cmd: %0d words captured after restart", got_d.size());
    endtask

    task automatic test_async_reset();
        int waited = 0;
        ts_sel    = 1'b0;
        stream_id = 32'h0BADF00D;
        plen      = 16'd4;
        wtp       = 32'd4;
        reset_cmd_pulse();
        kick();
        s_if.TVALID = 1'b1;
        s_if.TDATA  = 32'h12345678;
        m_if.TREADY = 1'b0;
        do begin
            @(negedge clk);
            #1;
            waited++;
        end while (status[27:24] !== 4'd2 && waited < 20);
        vectors++;
        if (status[27:24] !== 4'd2 || m_if.TVALID !== 1'b1) begin
            $display("FAIL arst_hdr: got state=%0d tvalid=%b required 2/1", status[27:24], m_if.TVALID);
            miscompares++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_if.TVALID !== 1'b0 || s_if.TREADY !== 1'b0 || m_if.TDATA !== 32'd0 || status[27:0] !== 28'd0) begin
            $display("FAIL arst_out: got tvalid=%b tready=%b tdata=%h status=%h required 0/0/0/low bits 0",
                     m_if.TVALID, s_if.TREADY, m_if.TDATA, status);
            miscompares++;
        end
        s_if.TVALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fill_src(4, 1'b1);
        build_expected();
        kick();
        run_stream(1'b0, 0, 500);
        vectors++;
        if (timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL arst_count: got %0d words (timeout=%0d) required %0d", got_d.size(), timed_out, exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL arst_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        vectors++;
        if (got_d.size() > 0 && got_d[0] !== 32'h10000006) begin
            $display("FAIL arst_hdr0: got %h required 10000006", got_d[0]);
            miscompares++;
        end
        $display("test_async_reset: %0d words captured after restart", got_d.size());
    endtask

    task automatic test_cfg_err();
        int traffic;
        logic [15:0] bad_len[2];
        bad_len[0] = 16'd0;
        bad_len[1] = 16'd65531;
        ts_sel = 1'b0;
        wtp    = 32'd5;
        for (int k = 0; k < 2; k++) begin
            plen = bad_len[k];
            reset_cmd_pulse();
            kick();
            traffic = 0;
            m_if.TREADY = 1'b1;
            repeat (15) begin
                @(negedge clk);
                #1;
                if (m_if.TVALID) traffic++;
            end
            vectors++;
            if (status[1] !== 1'b1 || status[27:24] !== 4'd9 || traffic !== 0 || status[0] !== 1'b0) begin
                $display("FAIL cfgerr_len%0d: got cfg_err=%b state=%0d beats=%0d done=%b required 1/9/0/0",
                         plen, status[1], status[27:24], traffic, status[0]);
                miscompares++;
            end
        end
        plen = 16'd65530;
        wtp  = 32'd3;
        stream_id = $urandom;
        fill_src(3, 1'b1);
        build_expected();
        reset_cmd_pulse();
        kick();
        run_stream(1'b0, 0, 500);
        vectors++;
        if (status[1] !== 1'b0 || timed_out || got_d.size() != exp_d.size()) begin
            $display("FAIL cfg_maxlen: got cfg_err=%b words=%0d required 0/%0d", status[1], got_d.size(), exp_d.size());
            miscompares++;
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                $display("FAIL cfg_maxlen_word%0d: got %h last=%0d required %h last=%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                miscompares++;
            end
        end
        $display("test_cfg_err: error and max-length cases applied");
    endtask

    task automatic test_passthrough();
        logic [31:0] st_before;
        @(negedge clk);
        #1;
        st_before = status;
        @(negedge clk);
        ctrl = 32'h4;
        for (int i = 0; i < 30; i++) begin
            s_if.TDATA  = $urandom;
            s_if.TVALID = $urandom_range(0, 1) != 0;
            s_if.TLAST  = $urandom_range(0, 1) != 0;
            m_if.TREADY = $urandom_range(0, 1) != 0;
            #1;
            vectors++;
            if (m_if.TDATA !== s_if.TDATA || m_if.TVALID !== s_if.TVALID || m_if.TLAST !== s_if.TLAST || s_if.TREADY !== m_if.TREADY) begin
                $display("FAIL pass_beat%0d: got %h/%b/%b rdy=%b required %h/%b/%b rdy=%b", i,
                         m_if.TDATA, m_if.TVALID, m_if.TLAST, s_if.TREADY, s_if.TDATA, s_if.TVALID, s_if.TLAST, m_if.TREADY);
                miscompares++;
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (status[27:0] !== st_before[27:0]) begin
            $display("FAIL pass_frozen: got status %h required low bits of %h", status, st_before);
            miscompares++;
        end
        ctrl = 32'd0;
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
        $display("test_passthrough: 30 beats applied");
    endtask

    initial begin
        rst_n       = 1'b0;
        ctrl        = 32'd0;
        ts_sel      = 1'b0;
        stream_id   = 32'd0;
        plen        = 16'd0;
        wtp         = 32'd0;
        sec         = 32'd0;
        fsec        = 64'd0;
        s_if.TDATA  = 32'd0;
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
        m_if.TREADY = 1'b0;

        test_reset();
        test_ts_packets();
        test_no_ts();
        test_throttle();
        test_pkt_cnt_wrap();
        test_reset_cmd();
        test_async_reset();
        test_cfg_err();
        test_passthrough();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
